// File: rtl/sa_cache_pkg.sv
// sa_cache_pkg: geometry constants and per-way tag entry type shared by sa_cache and sa_cache_plru
package sa_cache_pkg;
  localparam int TAG_W    = 18;
  localparam int INDEX_W  = 8;
  localparam int OFFSET_W = 6;
  localparam int WAYS     = 4;
  localparam int LINE_W   = 512;
  localparam int SETS     = 256;
  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } way_entry_t;
endpackage

// File: rtl/sa_cache_plru.sv
// sa_cache_plru: 4-way tree pseudo-LRU; in: i_tree, i_access, i_valid; out: o_victim (lowest invalid else PLRU), o_tree (access made most-recent)
module sa_cache_plru
  import sa_cache_pkg::*;
(
  input  logic [2:0]      i_tree,
  input  logic [1:0]      i_access,
  input  logic [WAYS-1:0] i_valid,
  output logic [1:0]      o_victim,
  output logic [2:0]      o_tree
);
  // tree[0]=1 points the victim at ways 2/3; tree[1] picks inside 0/1, tree[2] inside 2/3
  assign o_victim = !i_valid[0] ? 2'd0 : !i_valid[1] ? 2'd1 : !i_valid[2] ? 2'd2 : !i_valid[3] ? 2'd3 :
                    i_tree[0] ? {1'b1, i_tree[2]} : {1'b0, i_tree[1]};
  assign o_tree = i_access[1] ? {~i_access[0], i_tree[1], 1'b0} : {i_tree[2], ~i_access[0], 1'b1};
endmodule

// File: rtl/sa_cache.sv
// sa_cache: 4-way write-back write-allocate cache; CPU port (i_tag/i_index/i_offset/dataW/memRW -> o_data/line_data/cache_miss), refill (i_memory_line/i_memory_response), evict (o_evict/o_evict_data/o_evict_addr); CACHE_STATS_EN adds o_hit_count/o_miss_count
module sa_cache
  import sa_cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [TAG_W-1:0]    i_tag,
  input  logic [INDEX_W-1:0]  i_index,
  input  logic [OFFSET_W-1:0] i_offset,
  input  logic [31:0]         dataW,
  input  logic                memRW,
  input  logic [LINE_W-1:0]   i_memory_line,
  input  logic                i_memory_response,
  output logic [31:0]         o_data,
  output logic [LINE_W-1:0]   line_data,
  output logic                cache_miss,
  output logic                o_evict,
  output logic [LINE_W-1:0]   o_evict_data,
  output logic [31:0]         o_evict_addr
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]         o_hit_count,
  output logic [31:0]         o_miss_count
`endif
);
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [2:0]        plru_q [SETS];
  logic [TAG_W-1:0]  tag_q [SETS][WAYS];
  logic [LINE_W-1:0] data_q [SETS][WAYS];
  way_entry_t        ent [WAYS];
  logic              hit, refill, data_we, evict_d, evict_q, unused_ok;
  logic [1:0]        hit_way, victim, wr_way;
  logic [2:0]        tree_nxt, plru_d;
  logic [WAYS-1:0]   valid_d, dirty_d;
  logic [LINE_W-1:0] hit_line, line_d, evict_data_d, evict_data_q;
  logic [31:0]       evict_addr_d, evict_addr_q;
  logic [8:0]        word_lsb;
  always_comb begin
    hit = 1'b0;
    hit_way = 2'd0;
    for (int w = 0; w < WAYS; w++) begin
      ent[w] = '{valid: valid_q[i_index][w], dirty: dirty_q[i_index][w], tag: tag_q[i_index][w]};
      if (ent[w].valid && ent[w].tag == i_tag) begin
        hit = 1'b1;
        hit_way = 2'(w);
      end
    end
  end
  sa_cache_plru u_plru (
    .i_tree   (plru_q[i_index]),
    .i_access (wr_way),
    .i_valid  (valid_q[i_index]),
    .o_victim (victim),
    .o_tree   (tree_nxt)
  );
  always_comb begin
    word_lsb = {i_offset[5:2], 5'd0};
    hit_line = data_q[i_index][hit_way];
    refill = !hit && i_memory_response;
    wr_way = hit ? hit_way : victim;
    data_we = (hit && memRW) || refill;
    line_d = hit ? hit_line : i_memory_line;
    if (memRW) line_d[word_lsb +: 32] = dataW;
    valid_d = valid_q[i_index];
    dirty_d = dirty_q[i_index];
    if (refill) valid_d[victim] = 1'b1;
    if (data_we) dirty_d[wr_way] = memRW;
    plru_d = (hit || refill) ? tree_nxt : plru_q[i_index];
    evict_d = refill && ent[victim].valid && ent[victim].dirty;
    evict_data_d = evict_d ? data_q[i_index][victim] : evict_data_q;
    evict_addr_d = evict_d ? {ent[victim].tag, i_index, 6'd0} : evict_addr_q;
  end
  assign cache_miss   = !hit;
  assign line_data    = hit ? hit_line : '0;
  assign o_data       = hit ? hit_line[word_lsb +: 32] : 32'd0;
  assign o_evict      = evict_q;
  assign o_evict_data = evict_data_q;
  assign o_evict_addr = evict_addr_q;
  assign unused_ok    = &{1'b0, i_offset[1:0]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
      evict_q      <= 1'b0;
      evict_data_q <= '0;
      evict_addr_q <= '0;
    end else begin
      valid_q[i_index] <= valid_d;
      dirty_q[i_index] <= dirty_d;
      plru_q[i_index]  <= plru_d;
      evict_q          <= evict_d;
      evict_data_q     <= evict_data_d;
      evict_addr_q     <= evict_addr_d;
    end
  end
  // line and tag storage carry no reset; valid bits alone gate their use
  always_ff @(posedge clk) begin
    if (data_we) data_q[i_index][wr_way] <= line_d;
    if (refill) tag_q[i_index][victim] <= i_tag;
  end
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_d, hit_count_q, miss_count_d, miss_count_q;
  assign hit_count_d  = hit_count_q + {31'd0, hit};
  assign miss_count_d = miss_count_q + {31'd0, refill};
  assign o_hit_count  = hit_count_q;
  assign o_miss_count = miss_count_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end
`endif
endmodule

// File: tb/tb_sa_cache.sv
// tb_sa_cache: directed vector table plus randomized traffic checked against a behavioural cache model
module tb_sa_cache;
  import sa_cache_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic [17:0] i_tag = '0;
  logic [7:0] i_index = '0;
  logic [5:0] i_offset = '0;
  logic [31:0] dataW = '0;
  logic memRW = 1'b0, i_memory_response = 1'b0;
  logic [511:0] i_memory_line = '0;
  logic [31:0] o_data, o_evict_addr;
  logic [511:0] line_data, o_evict_data;
  logic cache_miss, o_evict;
`ifdef CACHE_STATS_EN
  logic [31:0] o_hit_count, o_miss_count;
`endif
  always #5 clk = ~clk;
  sa_cache dut (
    .clk(clk), .rst(rst), .i_tag(i_tag), .i_index(i_index), .i_offset(i_offset),
    .dataW(dataW), .memRW(memRW), .i_memory_line(i_memory_line), .i_memory_response(i_memory_response),
    .o_data(o_data), .line_data(line_data), .cache_miss(cache_miss), .o_evict(o_evict),
    .o_evict_data(o_evict_data), .o_evict_addr(o_evict_addr)
`ifdef CACHE_STATS_EN
    , .o_hit_count(o_hit_count), .o_miss_count(o_miss_count)
`endif
  );
  int passed = 0, total = 0;
  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  bit m_valid [SETS][WAYS];
  bit m_dirty [SETS][WAYS];
  logic [17:0] m_tag [SETS][WAYS];
  logic [31:0] m_word [SETS][WAYS][16];
  int last_pair [SETS];
  int last_in [SETS][2];
  bit exp_ev;
  logic [511:0] exp_ev_data;
  logic [31:0] exp_ev_addr;
  int unsigned m_hits, m_misses;
  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
      last_pair[s] = 1;
      last_in[s][0] = 1;
      last_in[s][1] = 1;
    end
    exp_ev = 0; exp_ev_data = '0; exp_ev_addr = '0; m_hits = 0; m_misses = 0;
  endtask
  function automatic int find(input logic [17:0] t, input int ix);
    for (int w = 0; w < WAYS; w++) if (m_valid[ix][w] && m_tag[ix][w] == t) return w;
    return -1;
  endfunction
  function automatic logic [511:0] pack(input int ix, input int w);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = m_word[ix][w][k];
    return l;
  endfunction
  // victim: first empty way, else the less recently used pair and within it the way not touched last
  function automatic int pick(input int ix);
    int p;
    for (int w = 0; w < WAYS; w++) if (!m_valid[ix][w]) return w;
    p = 1 - last_pair[ix];
    return p * 2 + (1 - last_in[ix][p]);
  endfunction
  task automatic touch(input int ix, input int w);
    last_pair[ix] = w / 2;
    last_in[ix][w / 2] = w % 2;
  endtask
  function automatic logic [511:0] mk(input logic [31:0] b);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = b + 32'(k);
    return l;
  endfunction
  function automatic logic [511:0] rnd_line();
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction
  task automatic step(input logic [17:0] t, input logic [7:0] ix, input logic [5:0] off, input bit rw,
                      input logic [31:0] wd, input bit resp, input logic [511:0] line,
                      output bit a_miss, output logic [31:0] a_data);
    int h, v;
    @(negedge clk);
    i_tag = t; i_index = ix; i_offset = off; memRW = rw; dataW = wd;
    i_memory_response = resp; i_memory_line = line;
    #1;
    h = find(t, int'(ix));
    a_miss = cache_miss;
    a_data = o_data;
    check("cache_miss", 512'(cache_miss), 512'(h < 0));
    check("o_data", 512'(o_data), h < 0 ? '0 : 512'(m_word[ix][h][off[5:2]]));
    check("line_data", line_data, h < 0 ? '0 : pack(int'(ix), h));
    @(posedge clk);
    exp_ev = 0;
    if (h >= 0) begin
      m_hits++;
      if (rw) begin
        m_word[ix][h][off[5:2]] = wd;
        m_dirty[ix][h] = 1;
      end
      touch(int'(ix), h);
    end else if (resp) begin
      v = pick(int'(ix));
      if (m_valid[ix][v] && m_dirty[ix][v]) begin
        exp_ev = 1;
        exp_ev_data = pack(int'(ix), v);
        exp_ev_addr = {m_tag[ix][v], ix, 6'd0};
      end
      for (int k = 0; k < 16; k++) m_word[ix][v][k] = line[k*32 +: 32];
      if (rw) m_word[ix][v][off[5:2]] = wd;
      m_valid[ix][v] = 1;
      m_dirty[ix][v] = rw;
      m_tag[ix][v] = t;
      touch(int'(ix), v);
      m_misses++;
    end
    #1;
    check("o_evict", 512'(o_evict), 512'(exp_ev));
    check("o_evict_data", o_evict_data, exp_ev_data);
    check("o_evict_addr", 512'(o_evict_addr), 512'(exp_ev_addr));
`ifdef CACHE_STATS_EN
    check("o_hit_count", 512'(o_hit_count), 512'(m_hits));
    check("o_miss_count", 512'(o_miss_count), 512'(m_misses));
`endif
  endtask
  typedef struct {
    logic [17:0] t; logic [7:0] ix; logic [5:0] off; bit rw; logic [31:0] wd;
    bit resp; logic [31:0] base; bit e_miss; logic [31:0] e_data; bit e_ev; logic [31:0] e_ev_addr;
  } vec_t;
  vec_t tbl [$];
  task automatic add(input int t, input int ix, input int off, input bit rw, input logic [31:0] wd,
                     input bit resp, input logic [31:0] base, input bit em, input logic [31:0] ed,
                     input bit ee, input logic [31:0] ea);
    vec_t v;
    v.t = 18'(t); v.ix = 8'(ix); v.off = 6'(off); v.rw = rw; v.wd = wd; v.resp = resp; v.base = base;
    v.e_miss = em; v.e_data = ed; v.e_ev = ee; v.e_ev_addr = ea;
    tbl.push_back(v);
  endtask
  initial begin
    bit am, rw;
    logic [31:0] ad, wd;
    logic [17:0] t;
    logic [7:0] ix;
    logic [5:0] off;
    add(0, 0, 4, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 4, 0, 0, 1, 32'hDEADBEEE, 1, 0, 0, 0);
    add(0, 0, 4, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0);
    add(0, 0, 8, 1, 32'h12345678, 0, 0, 0, 32'hDEADBEF0, 0, 0);
    add(0, 0, 8, 0, 0, 0, 0, 0, 32'h12345678, 0, 0);
    add(0, 0, 11, 0, 0, 0, 0, 0, 32'h12345678, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      add(k, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      add(k, 5, 0, 0, 0, 1, 32'(k) << 8, 1, 0, 0, 0);
    end
    add(5, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(5, 5, 0, 0, 0, 1, 32'h500, 1, 0, 0, 0);
    add(1, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(2, 5, 12, 1, 32'hAAAA5555, 0, 0, 0, 32'h203, 0, 0);
    add(3, 5, 0, 0, 0, 0, 0, 0, 32'h300, 0, 0);
    add(5, 5, 0, 0, 0, 0, 0, 0, 32'h500, 0, 0);
    add(4, 5, 0, 0, 0, 0, 0, 0, 32'h400, 0, 0);
    add(6, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(6, 5, 0, 0, 0, 1, 32'h600, 1, 0, 1, 32'h8140);
    add(6, 5, 0, 0, 0, 0, 0, 0, 32'h600, 0, 0);
    add(2, 5, 12, 0, 0, 0, 0, 1, 0, 0, 0);
    #1 rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset o_evict", 512'(o_evict), 512'(0));
    check("reset o_evict_addr", 512'(o_evict_addr), 512'(0));
    check("reset cache_miss", 512'(cache_miss), 512'(1));
    rst = 1'b0;
    foreach (tbl[i]) begin
      step(tbl[i].t, tbl[i].ix, tbl[i].off, tbl[i].rw, tbl[i].wd, tbl[i].resp,
           tbl[i].resp ? mk(tbl[i].base) : '0, am, ad);
      check($sformatf("vec%0d miss", i), 512'(am), 512'(tbl[i].e_miss));
      check($sformatf("vec%0d data", i), 512'(ad), 512'(tbl[i].e_data));
      check($sformatf("vec%0d evict", i), 512'(o_evict), 512'(tbl[i].e_ev));
      if (tbl[i].e_ev) begin
        check($sformatf("vec%0d evict addr", i), 512'(o_evict_addr), 512'(tbl[i].e_ev_addr));
        check($sformatf("vec%0d evict word3", i), 512'(o_evict_data[127:96]), 512'(32'hAAAA5555));
      end
    end
    // reset in the middle of an outstanding miss
    step(7, 0, 0, 0, 0, 0, '0, am, ad);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst o_evict_data", o_evict_data, '0);
    check("async rst o_evict_addr", 512'(o_evict_addr), 512'(0));
    model_reset();
    #1 rst = 1'b0;
    step(0, 0, 4, 0, 0, 0, '0, am, ad);
    check("post-reset old hit misses", 512'(am), 512'(1));
    // write miss merges store data into the refilled line; its later eviction carries it
    step(9, 3, 20, 1, 32'hCAFEF00D, 0, '0, am, ad);
    step(9, 3, 20, 1, 32'hCAFEF00D, 1, mk(32'h900), am, ad);
    step(9, 3, 20, 0, 0, 0, '0, am, ad);
    check("write-miss merged word", 512'(ad), 512'(32'hCAFEF00D));
    step(9, 3, 16, 0, 0, 0, '0, am, ad);
    check("write-miss memory word", 512'(ad), 512'(32'h904));
    for (int k = 10; k <= 12; k++) step(18'(k), 3, 0, 0, 0, 1, mk(32'(k) << 8), am, ad);
    step(13, 3, 0, 0, 0, 1, mk(32'hD00), am, ad);
    check("write-miss evict", 512'(o_evict), 512'(1));
    check("write-miss evict addr", 512'(o_evict_addr), 512'(32'h240C0));
    check("write-miss evict word5", 512'(o_evict_data[191:160]), 512'(32'hCAFEF00D));
    step(13, 3, 0, 0, 0, 0, '0, am, ad);
    check("evict one cycle", 512'(o_evict), 512'(0));
    for (int n = 0; n < 1500; n++) begin
      t = 18'($urandom_range(0, 5));
      ix = 8'($urandom_range(0, 3));
      off = 6'($urandom);
      rw = 1'($urandom_range(0, 1));
      wd = $urandom;
      step(t, ix, off, rw, wd, $urandom_range(0, 3) == 0, rnd_line(), am, ad);
      for (int g = 0; am && g < 8; g++)
        step(t, ix, off, rw, wd, g == 7 || $urandom_range(0, 1) == 1, rnd_line(), am, ad);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
